// File: rtl/sha_pkg.sv
// -----------------------------------------------------------------------------
// sha_pkg
// Shared definitions for the SHA-256 block-load controller.
//   state_t / ST_*     : controller state encoding
//   ADDR_W_SEL         : mux address that selects the W buffer
//   ADDR_VAR_BASE      : mux address of working variable 'a' (a..h = 1..8)
//   NUM_VAR / NUM_W    : words loaded per block into each destination
// -----------------------------------------------------------------------------
package sha_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOAD_VAR = 3'd1;
  localparam state_t ST_LOAD_W   = 3'd2;
  localparam state_t ST_START    = 3'd3;
  localparam state_t ST_WAIT     = 3'd4;

  localparam logic [3:0] ADDR_W_SEL    = 4'd0;
  localparam logic [3:0] ADDR_VAR_BASE = 4'd1;

  localparam int NUM_VAR = 8;
  localparam int NUM_W   = 16;

endpackage

// File: rtl/sha_load_ctrl.sv
// -----------------------------------------------------------------------------
// sha_load_ctrl
// Sequences the loading of one SHA-256 block into the hash core: the 8
// working variables (unless skip_var chains them from the previous block),
// then the 16 message words, then a start pulse to the round core and a wait
// for its completion.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start, skip_var : begin a block load (IDLE only); skip_var loads W only
//   in_valid/in_data/in_ready : word stream from the source
//   out_addr/out_data         : steering to the input mux (0 = W, 1..8 = a..h)
//   var_we, w_we, w_idx       : write strobes and W index
//   core_start, core_done     : round core start pulse / completion
//   busy, blk_done            : status, one-cycle block-complete pulse
//   dbg_state                 : current FSM state for observation
//
// Handshake: a word transfers in any cycle where in_valid && in_ready.
// in_ready depends only on the registered state (never on in_valid), the
// source must hold in_data stable while in_valid is high and in_ready low is
// not required because nothing is captured then. There is no skid buffer:
// the accepting cycle's strobe is issued combinationally in the same cycle.
// -----------------------------------------------------------------------------
module sha_load_ctrl
  import sha_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              skip_var,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [3:0]        out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              var_we,
  output logic              w_we,
  output logic [3:0]        w_idx,
  output logic              core_start,
  input  logic              core_done,
  output logic              busy,
  output logic              blk_done,
  output state_t            dbg_state
);

  localparam logic [3:0] LAST_VAR = 4'(NUM_VAR - 1);
  localparam logic [3:0] LAST_W   = 4'(NUM_W - 1);

  state_t     state_q, state_d;
  logic [3:0] var_cnt_q, var_cnt_d;
  logic [3:0] w_cnt_q, w_cnt_d;
  logic       blk_done_q, blk_done_d;
  logic       accept;

  assign accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      var_cnt_q  <= 4'd0;
      w_cnt_q    <= 4'd0;
      blk_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      var_cnt_q  <= var_cnt_d;
      w_cnt_q    <= w_cnt_d;
      blk_done_q <= blk_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    var_cnt_d  = var_cnt_q;
    w_cnt_d    = w_cnt_q;
    blk_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          var_cnt_d = 4'd0;
          w_cnt_d   = 4'd0;
          state_d   = skip_var ? ST_LOAD_W : ST_LOAD_VAR;
        end
      end
      ST_LOAD_VAR: begin
        if (accept) begin
          var_cnt_d = var_cnt_q + 4'd1;
          if (var_cnt_q == LAST_VAR) state_d = ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (accept) begin
          w_cnt_d = w_cnt_q + 4'd1;
          if (w_cnt_q == LAST_W) state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // core_done is only meaningful here; the blk_done pulse lands in
        // the first IDLE cycle so a new start can be taken that same cycle.
        if (core_done) begin
          state_d    = ST_IDLE;
          blk_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready   = 1'b0;
    out_addr   = ADDR_W_SEL;
    w_idx      = 4'd0;
    var_we     = 1'b0;
    w_we       = 1'b0;
    core_start = 1'b0;
    case (state_q)
      ST_LOAD_VAR: begin
        in_ready = 1'b1;
        out_addr = ADDR_VAR_BASE + var_cnt_q;
        var_we   = in_valid;
      end
      ST_LOAD_W: begin
        in_ready = 1'b1;
        w_idx    = w_cnt_q;
        w_we     = in_valid;
      end
      ST_START: core_start = 1'b1;
      default: ;
    endcase
  end

  assign out_data  = in_data;
  assign busy      = (state_q != ST_IDLE);
  assign blk_done  = blk_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sha_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sha_load_ctrl
// Directed bench for sha_load_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Every observed strobe
// is matched in order against an expected queue filled by the directed steps.
// -----------------------------------------------------------------------------
module tb_sha_load_ctrl;
  import sha_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        rst, start, skip_var, in_valid, core_done;
  logic [31:0] in_data;
  logic        in_ready, var_we, w_we, core_start, busy, blk_done;
  logic [3:0]  out_addr, w_idx;
  logic [31:0] out_data;
  state_t      dbg_state;

  sha_load_ctrl #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .skip_var   (skip_var),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .var_we     (var_we),
    .w_we       (w_we),
    .w_idx      (w_idx),
    .core_start (core_start),
    .core_done  (core_done),
    .busy       (busy),
    .blk_done   (blk_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- checking ----------------
  int n_assert = 0;
  int n_fail   = 0;
  int n_cs     = 0;
  int n_bd     = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard entry: {is_w, addr, w_idx, data}
  logic [40:0] exp_q[$];

  task automatic exp_vars(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({1'b0, 4'(i + 1), 4'd0, base + 32'(i)});
  endtask

  task automatic exp_ws(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({1'b1, 4'd0, 4'(i), base + 32'(i)});
  endtask

  always @(negedge clk) begin
    logic [40:0] obs;
    if (mon_en) begin
      chk("strobe_vs_accept", 64'(var_we | w_we), 64'(in_valid & in_ready));
      chk("one_strobe", 64'(var_we & w_we), 64'd0);
      if (var_we || w_we) begin
        obs = {w_we, out_addr, (w_we ? w_idx : 4'd0), out_data};
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL unexpected_strobe: observed=%0h expected=none", obs);
        end else begin
          chk("strobe_word", 64'(obs), 64'(exp_q.pop_front()));
        end
      end
      if (core_start) n_cs++;
      if (blk_done)   n_bd++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic skip);
    start    = 1'b1;
    skip_var = skip;
    next();
    start    = 1'b0;
    skip_var = 1'b0;
  endtask

  // Offers n words base, base+1, ... ; with gaps, in_valid is randomised and
  // the data bus carries junk on idle cycles.
  task automatic feed(input int n, input logic [31:0] base, input bit gaps,
                      output int cycles);
    int sent = 0;
    cycles = 0;
    while (sent < n && cycles < 2000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? base + 32'(sent) : $urandom;
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      next();
      cycles++;
    end
    in_valid = 1'b0;
    chk("feed_complete", 64'(sent), 64'(n));
  endtask

  task automatic finish_block();
    core_done = 1'b1;
    next();
    core_done = 1'b0;
    @(negedge clk);
    chk("blk_done_pulse", 64'(blk_done), 64'd1);
    chk("idle_after_done", 64'(dbg_state), 64'(ST_IDLE));
    chk("busy_after_done", 64'(busy), 64'd0);
    next();
    @(negedge clk);
    chk("blk_done_one_cycle", 64'(blk_done), 64'd0);
    next();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c;
    int t0;
    rst = 1'b1; start = 1'b0; skip_var = 1'b0;
    in_valid = 1'b0; in_data = 32'd0; core_done = 1'b0;
    next();
    next();
    @(negedge clk);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_strobes", 64'({var_we, w_we, core_start, blk_done}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr_idx", 64'({out_addr, w_idx}), 64'd0);
    next();
    rst    = 1'b0;
    mon_en = 1'b1;

    // Valid offered in IDLE must not be taken
    in_valid = 1'b1; in_data = 32'hdead_beef;
    @(negedge clk);
    chk("idle_no_ready", 64'(in_ready), 64'd0);
    next();
    in_valid = 1'b0;

    // Full load, valid every cycle
    exp_vars(32'h1000, 8);
    exp_ws(32'h1008, 16);
    t0 = cyc;
    do_start(1'b0);
    feed(24, 32'h1000, 1'b0, c);
    chk("full_no_stall", 64'(c), 64'd24);
    @(negedge clk);
    chk("full_core_start", 64'(core_start), 64'd1);
    chk("full_latency", 64'(cyc - t0 + 1), 64'd26);
    chk("start_not_ready", 64'(in_ready), 64'd0);
    chk("full_all_words", 64'(exp_q.size()), 64'd0);
    next();
    in_valid = 1'b1;  // held in WAIT: must produce no strobe
    @(negedge clk);
    chk("wait_state", 64'(dbg_state), 64'(ST_WAIT));
    chk("core_start_one_cycle", 64'(core_start), 64'd0);
    chk("wait_busy", 64'(busy), 64'd1);
    next();
    in_valid = 1'b0;
    finish_block();
    chk("blk1_core_starts", 64'(n_cs), 64'd1);
    chk("blk1_blk_dones", 64'(n_bd), 64'd1);

    // Chained block with spurious core_done in LOAD_W / START and start in WAIT
    exp_ws(32'h2000, 16);
    do_start(1'b1);
    feed(8, 32'h2000, 1'b0, c);
    core_done = 1'b1;
    @(negedge clk);
    chk("chain_in_load_w", 64'(dbg_state), 64'(ST_LOAD_W));
    chk("chain_w_idx_mid", 64'(w_idx), 64'd8);
    next();
    core_done = 1'b0;
    @(negedge clk);
    chk("spurious_done_ignored", 64'(dbg_state), 64'(ST_LOAD_W));
    chk("w_idx_held", 64'(w_idx), 64'd8);
    next();
    feed(8, 32'h2008, 1'b0, c);
    core_done = 1'b1;
    @(negedge clk);
    chk("chain_core_start", 64'(core_start), 64'd1);
    next();
    core_done = 1'b0;
    @(negedge clk);
    chk("done_in_start_ignored", 64'(dbg_state), 64'(ST_WAIT));
    chk("no_early_blk_done", 64'(blk_done), 64'd0);
    next();
    start = 1'b1;
    next();
    start = 1'b0;
    @(negedge clk);
    chk("start_in_wait_ignored", 64'(dbg_state), 64'(ST_WAIT));
    chk("no_extra_core_start", 64'(n_cs), 64'd2);
    next();
    finish_block();
    chk("blk2_blk_dones", 64'(n_bd), 64'd2);

    // Full load with random gaps on in_valid
    exp_vars(32'h3000, 8);
    exp_ws(32'h3008, 16);
    do_start(1'b0);
    feed(24, 32'h3000, 1'b1, c);
    chk("gaps_min_cycles", 64'(c >= 24), 64'd1);
    @(negedge clk);
    chk("gaps_core_start", 64'(core_start), 64'd1);
    chk("gaps_all_words", 64'(exp_q.size()), 64'd0);
    next();
    finish_block();

    // Reset after 5 variable words
    exp_vars(32'h4000, 5);
    do_start(1'b0);
    feed(5, 32'h4000, 1'b0, c);
    rst = 1'b1;
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    next();

    // Reload from addr 1, then back-to-back start in the blk_done cycle
    exp_vars(32'h5000, 8);
    exp_ws(32'h5008, 16);
    do_start(1'b0);
    feed(24, 32'h5000, 1'b0, c);
    @(negedge clk);
    chk("reload_core_start", 64'(core_start), 64'd1);
    next();
    core_done = 1'b1;
    next();
    core_done = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    chk("b2b_blk_done", 64'(blk_done), 64'd1);
    chk("b2b_idle", 64'(dbg_state), 64'(ST_IDLE));
    next();
    start = 1'b0;
    @(negedge clk);
    chk("b2b_load_var", 64'(dbg_state), 64'(ST_LOAD_VAR));
    chk("b2b_addr1", 64'(out_addr), 64'd1);
    chk("b2b_ready", 64'(in_ready), 64'd1);
    next();
    exp_vars(32'h6000, 8);
    exp_ws(32'h6008, 16);
    feed(24, 32'h6000, 1'b0, c);
    @(negedge clk);
    chk("b2b_core_start", 64'(core_start), 64'd1);
    next();
    finish_block();

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_core_starts", 64'(n_cs), 64'd5);
    chk("final_blk_dones", 64'(n_bd), 64'd5);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
